ef_i2s_tdm_rx: RTL and testbench

//  Parametrised I2S/left-justified/TDM receive master: generates sck and ws, and captures sdi.

---
 rtl/ef_i2s_tdm_rx_if.sv | 31 +++
 rtl/ef_i2s_tdm_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_ef_i2s_tdm_rx.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ef_i2s_tdm_rx_if.sv
// FIFO drain bus of the I2S/LJ/TDM receiver: read strobe, head data,
// level reporting and the sticky overrun flag with its clear.
interface ef_i2s_tdm_rx_if #(
    parameter int SW  = 32,
    parameter int NCH = 8,
    parameter int AW  = 5
);
    localparam int CW = $clog2(NCH);

    logic              fifo_rd;
    logic [CW+SW-1:0]  fifo_rdata;
    logic [AW:0]       fifo_level;
    logic [AW:0]       fifo_level_threshold;
    logic              fifo_level_above;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overrun;
    logic              overrun_clr;

    // Bus wrapper side: pops entries, sets the threshold, clears overrun.
    modport master (
        output fifo_rd, fifo_level_threshold, overrun_clr,
        input  fifo_rdata, fifo_level, fifo_level_above, fifo_full, fifo_empty, overrun
    );

    // Receiver side: owns the FIFO and status.
    modport slave (
        input  fifo_rd, fifo_level_threshold, overrun_clr,
        output fifo_rdata, fifo_level, fifo_level_above, fifo_full, fifo_empty, overrun
    );
endinterface

// File: rtl/ef_i2s_tdm_rx.sv
// I2S / left-justified / TDM receive master. Generates sck and ws from clk,
// shifts sdi in MSB first, extends each sample to SW bits and pushes
// {slot, sample} into an internal FIFO drained through the interface port.
module ef_i2s_tdm_rx #(
    parameter int SW  = 32,
    parameter int NCH = 8,
    parameter int AW  = 5,
    localparam int CW  = $clog2(NCH),
    localparam int SSW = $clog2(SW) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   slots,
    input  logic [NCH-1:0]  slot_mask,
    input  logic [SSW-1:0]  sample_size,
    input  logic            sign_extend,
    input  logic [7:0]      sck_prescaler,
    output logic            sck,
    output logic            ws,
    input  logic            sdi,
    ef_i2s_tdm_rx_if.slave  fifo
);
    localparam int BW    = $clog2(SW);
    localparam int DEPTH = 2 ** AW;
    localparam logic [BW-1:0] LAST_BIT = BW'(SW - 1);

    // ---------------------------------------------------------------- state
    logic [7:0]       cnt_reg;
    logic             sck_reg;
    logic             ws_reg;
    logic [CW-1:0]    slot_reg;
    logic [BW-1:0]    bit_reg;
    logic [SW-1:0]    shift_reg;
    logic             primed_reg;
    logic [1:0]       mode_reg;
    logic [CW-1:0]    slots_reg;
    logic [SSW-1:0]   width_reg;
    logic             push_reg;
    logic [CW+SW-1:0] push_data_reg;

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             overrun_reg;
    logic [CW+SW-1:0] mem [DEPTH];

    // ------------------------------------------------------- combinational
    logic             tick, rise, fall;
    logic             is_tdm, is_lj;
    logic [1:0]       mode_eff;
    logic [SSW-1:0]   width_eff;
    logic [CW-1:0]    last_slot;
    logic             slot_end, frame_end;
    logic [BW-1:0]    nxt_bit, la_bit, dec_bit;
    logic [CW-1:0]    nxt_slot, la_slot, dec_slot;
    logic             la_end;
    logic             ws_next;
    logic [SW-1:0]    shift_next;
    logic [BW-1:0]    msb_idx;
    logic             sign_bit;
    logic [SW-1:0]    ext_data;
    logic             full, empty, do_pop, do_wr, drop;

    assign tick = en && (cnt_reg == 8'd0);
    assign rise = tick && !sck_reg;
    assign fall = tick && sck_reg;

    // Mode 11 behaves as I2S; sample_size of 0 or beyond SW means full slot.
    assign mode_eff  = (mode == 2'b11) ? 2'b00 : mode;
    assign width_eff = (sample_size == '0 || sample_size > SSW'(SW)) ? SSW'(SW) : sample_size;

    assign is_tdm = (mode_reg == 2'b10);
    assign is_lj  = (mode_reg == 2'b01);

    // Next position on a falling edge, plus a one-bit lookahead so ws can
    // lead the data by one sck in I2S and TDM.
    always_comb begin
        last_slot = is_tdm ? slots_reg : CW'(1);
        slot_end  = (bit_reg == LAST_BIT);
        frame_end = slot_end && (slot_reg == last_slot);
        nxt_bit   = slot_end ? '0 : bit_reg + 1'b1;
        nxt_slot  = frame_end ? '0 : (slot_end ? slot_reg + 1'b1 : slot_reg);
        la_end    = (nxt_bit == LAST_BIT);
        la_bit    = la_end ? '0 : nxt_bit + 1'b1;
        la_slot   = (la_end && nxt_slot == last_slot) ? '0
                  : (la_end ? nxt_slot + 1'b1 : nxt_slot);
        dec_slot  = is_lj ? nxt_slot : la_slot;
        dec_bit   = is_lj ? nxt_bit : la_bit;
        ws_next   = is_tdm ? (dec_slot == '0 && dec_bit == '0) : (dec_slot == CW'(1));
    end

    // Only the first W bits of a slot are shifted in; the rest are ignored.
    always_comb begin
        shift_next = shift_reg;
        if (rise && ({1'b0, bit_reg} < width_reg))
            shift_next = {shift_reg[SW-2:0], sdi};
    end

    assign msb_idx  = BW'(width_reg - SSW'(1));
    assign sign_bit = shift_next[msb_idx];

    for (genvar gi = 0; gi < SW; gi++) begin : g_ext
        assign ext_data[gi] = (SSW'(gi) < width_reg) ? shift_next[gi] : (sign_extend & sign_bit);
    end

    // Prescaler and bit clock; idle forces sck low and reloads the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
            sck_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg <= sck_prescaler;
            sck_reg <= 1'b0;
        end else if (cnt_reg == 8'd0) begin
            cnt_reg <= sck_prescaler;
            sck_reg <= ~sck_reg;
        end else begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    // Frame position, ws, primed flag and per-frame configuration snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg   <= '0;
            bit_reg    <= '0;
            ws_reg     <= 1'b0;
            primed_reg <= 1'b0;
            mode_reg   <= 2'b00;
            slots_reg  <= '0;
            width_reg  <= SSW'(SW);
        end else if (!en) begin
            slot_reg   <= '0;
            bit_reg    <= '0;
            ws_reg     <= 1'b0;
            primed_reg <= 1'b0;
            mode_reg   <= mode_eff;
            slots_reg  <= slots;
            width_reg  <= width_eff;
        end else if (fall) begin
            slot_reg <= nxt_slot;
            bit_reg  <= nxt_bit;
            ws_reg   <= ws_next;
            if (slot_end)
                primed_reg <= 1'b1;
            if (frame_end) begin
                mode_reg  <= mode_eff;
                slots_reg <= slots;
                width_reg <= width_eff;
            end
        end
    end

    // Shift register (cleared at each slot start) and the push request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg     <= '0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
        end else begin
            push_reg <= rise && slot_end && primed_reg && slot_mask[slot_reg];
            if (rise && slot_end)
                push_data_reg <= {slot_reg, ext_data};
            if (!en)
                shift_reg <= '0;
            else if (fall && slot_end)
                shift_reg <= '0;
            else
                shift_reg <= shift_next;
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign full   = (level_reg == DEPTH[AW:0]);
    assign empty  = (level_reg == '0);
    assign do_pop = fifo.fifo_rd && !empty;
    assign do_wr  = push_reg && (!full || fifo.fifo_rd);
    assign drop   = push_reg && full && !fifo.fifo_rd;

    // Pointers and level; a simultaneous write and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sample storage; the empty flag masks any stale contents after reset.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    // Sticky overrun; a drop in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_reg <= 1'b0;
        else if (drop)
            overrun_reg <= 1'b1;
        else if (fifo.overrun_clr)
            overrun_reg <= 1'b0;
    end

    assign sck                   = sck_reg;
    assign ws                    = ws_reg;
    assign fifo.fifo_rdata       = empty ? '0 : mem[rd_ptr_reg];
    assign fifo.fifo_level       = level_reg;
    assign fifo.fifo_level_above = (level_reg > fifo.fifo_level_threshold);
    assign fifo.fifo_full        = full;
    assign fifo.fifo_empty       = empty;
    assign fifo.overrun          = overrun_reg;
endmodule

// File: tb/tb_ef_i2s_tdm_rx.sv
// Directed bench for ef_i2s_tdm_rx: an I2S/LJ/TDM transmitter model drives sdi
// from its own frame position, expected FIFO entries go to a queue and are
// compared as the FIFO is drained.
module tb_ef_i2s_tdm_rx;
    localparam int SW  = 32;
    localparam int NCH = 8;
    localparam int AW  = 5;
    localparam int CW  = 3;
    localparam int SSW = 6;
    localparam int CLK_HALF = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [1:0]     mode;
    logic [CW-1:0]  slots;
    logic [NCH-1:0] slot_mask;
    logic [SSW-1:0] sample_size;
    logic           sign_extend;
    logic [7:0]     presc;
    logic           sdi;
    wire            sck;
    wire            ws;

    ef_i2s_tdm_rx_if #(.SW(SW), .NCH(NCH), .AW(AW)) bus ();

    ef_i2s_tdm_rx #(.SW(SW), .NCH(NCH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .mode          (mode),
        .slots         (slots),
        .slot_mask     (slot_mask),
        .sample_size   (sample_size),
        .sign_extend   (sign_extend),
        .sck_prescaler (presc),
        .sck           (sck),
        .ws            (ws),
        .sdi           (sdi),
        .fifo          (bus)
    );

    always #CLK_HALF clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [CW+SW-1:0] q[$];
    bit   drain = 1'b1;
    bit   rd_on_push = 1'b0;
    bit   exp_ovr = 1'b0;
    bit   abort = 1'b0;
    int   pos;
    bit   primed;
    int   nslot_b;
    int   w_b;
    logic [31:0] samp [NCH];
    longint prev_rise;
    bit   prev_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk step; also drains the FIFO against the scoreboard when enabled.
    task automatic tick();
        @(negedge clk);
        if (bus.fifo_rd) begin
            bus.fifo_rd = 1'b0;
        end else if (drain && !bus.fifo_empty) begin
            chk("pop_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                $display("pop: rdata=%0h expected=%0h", bus.fifo_rdata, q[0]);
                chk("rdata", bus.fifo_rdata, q.pop_front());
            end
            bus.fifo_rd = 1'b1;
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_level(input logic lv);
        int n = 0;
        while (sck !== lv && n < 4000) begin
            tick();
            n++;
        end
        if (sck !== lv) begin
            chk("sck_timeout", sck, lv);
            abort = 1'b1;
        end
    endtask

    function automatic logic bit_at(input int p);
        int s = (p / SW) % nslot_b;
        int b = p % SW;
        if (b < w_b) return samp[s][w_b-1-b];
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic ws_model(input int p);
        int pp = p + ((mode == 2'b01) ? 0 : 1);
        if (mode == 2'b10) return (pp % (SW * nslot_b)) == 0;
        return ((pp / SW) % 2) == 1;
    endfunction

    function automatic logic [31:0] ext_model(input logic [31:0] v);
        logic [31:0] m;
        logic [31:0] r;
        m = (w_b >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w_b) - 32'd1);
        r = v & m;
        if (sign_extend && v[w_b-1]) r = r | ~m;
        return r;
    endfunction

    task automatic expect_push(input int s);
        logic [CW+SW-1:0] e;
        e = {CW'(s), ext_model(samp[s])};
        if (rd_on_push) begin
            chk("head_at_full", bus.fifo_rdata, q[0]);
            void'(q.pop_front());
            q.push_back(e);
            bus.fifo_rd = 1'b1;
        end else if (!drain && q.size() >= (1 << AW)) begin
            exp_ovr = 1'b1;
        end else begin
            q.push_back(e);
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [CW-1:0] sl, input logic [NCH-1:0] mk,
                         input logic [SSW-1:0] ss, input logic se, input logic [7:0] p);
        en = 1'b0;
        mode = m; slots = sl; slot_mask = mk; sample_size = ss; sign_extend = se; presc = p;
        nslot_b = (m == 2'b10) ? int'(sl) + 1 : 2;
        w_b = (ss == 0 || ss > SSW'(SW)) ? SW : int'(ss);
        settle(2);
        pos = 0; primed = 1'b0; prev_valid = 1'b0;
        en = 1'b1;
        chk("ws_at_enable", ws, 1'b0);
    endtask

    task automatic run_bits(input int n);
        for (int i = 0; i < n && !abort; i++) begin
            sdi = bit_at(pos);
            wait_level(1'b1);
            if (abort) break;
            if (prev_valid) chk("sck_period", $time - prev_rise, 2 * (int'(presc) + 1) * 2 * CLK_HALF);
            prev_rise = $time;
            prev_valid = 1'b1;
            if ((pos % SW) == SW - 1 && primed && slot_mask[(pos / SW) % nslot_b])
                expect_push((pos / SW) % nslot_b);
            wait_level(1'b0);
            if (abort) break;
            pos++;
            if ((pos % SW) == 0) primed = 1'b1;
            chk("ws", ws, ws_model(pos));
        end
    endtask

    task automatic stop();
        en = 1'b0;
        tick();
        chk("sck_idle", sck, 1'b0);
        chk("ws_idle", ws, 1'b0);
        settle(12);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; slots = '0; slot_mask = '0;
        sample_size = '0; sign_extend = 1'b0; presc = 8'd0; sdi = 1'b0;
        bus.fifo_rd = 1'b0; bus.fifo_level_threshold = '0; bus.overrun_clr = 1'b0;
        #1;
        chk("rst_sck", sck, 1'b0);
        chk("rst_ws", ws, 1'b0);
        chk("rst_empty", bus.fifo_empty, 1'b1);
        chk("rst_full", bus.fifo_full, 1'b0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_rdata", bus.fifo_rdata, 0);
        settle(3);
        rst_n = 1'b1;
        settle(2);

        // I2S, 24-bit signed samples, both slots
        samp[0] = 32'h0080_0001; samp[1] = 32'h0012_3456;
        start(2'b00, 3'd0, 8'h03, 6'd24, 1'b1, 8'd1);
        run_bits(192);
        stop();
        chk("t1_drained", q.size(), 0);
        $display("t1 i2s done: checks=%0d", checks);

        // disable mid-slot, then re-enable
        start(2'b00, 3'd0, 8'h03, 6'd24, 1'b1, 8'd1);
        run_bits(40);
        en = 1'b0;
        tick();
        chk("dis_sck", sck, 1'b0);
        chk("dis_ws", ws, 1'b0);
        settle(20);
        chk("dis_no_push", bus.fifo_level, 0);
        start(2'b00, 3'd0, 8'h03, 6'd24, 1'b1, 8'd1);
        run_bits(128);
        stop();
        chk("t6_drained", q.size(), 0);
        $display("t6 disable/re-enable done: checks=%0d", checks);

        // TDM, 4 slots, slots 1 and 3 enabled, 16-bit zero-extended
        for (int k = 0; k < NCH; k++) samp[k] = 32'h0000_A000 + k;
        start(2'b10, 3'd3, 8'h0A, 6'd16, 1'b0, 8'd0);
        run_bits(256);
        stop();
        chk("t2_drained", q.size(), 0);
        $display("t2 tdm done: checks=%0d", checks);

        // left-justified, 8-bit
        samp[0] = 32'h0000_005A; samp[1] = 32'h0000_00C3;
        start(2'b01, 3'd0, 8'h01, 6'd8, 1'b0, 8'd2);
        run_bits(96);
        stop();
        chk("t3_drained", q.size(), 0);
        $display("t3 lj done: checks=%0d", checks);

        // overflow: 33 pushes without reads, sample_size 0 means full width
        drain = 1'b0;
        exp_ovr = 1'b0;
        for (int k = 0; k < NCH; k++) samp[k] = $urandom;
        start(2'b10, 3'd7, 8'hFF, 6'd0, 1'b1, 8'd0);
        run_bits(1088);
        stop();
        chk("ovf_full", bus.fifo_full, 1'b1);
        chk("ovf_level", bus.fifo_level, q.size());
        chk("ovf_empty", bus.fifo_empty, 1'b0);
        chk("ovf_overrun", bus.overrun, exp_ovr);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        chk("ovr_clr", bus.overrun, 1'b0);
        rd_on_push = 1'b1;
        start(2'b10, 3'd7, 8'hFF, 6'd0, 1'b1, 8'd0);
        run_bits(64);
        rd_on_push = 1'b0;
        stop();
        chk("push_rd_level", bus.fifo_level, 32);
        chk("push_rd_overrun", bus.overrun, 1'b0);
        drain = 1'b1;
        settle(100);
        chk("t4_drained", q.size(), 0);
        chk("t4_empty", bus.fifo_empty, 1'b1);
        $display("t4 overrun done: checks=%0d", checks);

        // threshold compare and pop from empty
        drain = 1'b0;
        bus.fifo_level_threshold = 6'd3;
        start(2'b10, 3'd7, 8'hFF, 6'd12, 1'b1, 8'd0);
        run_bits(128);
        stop();
        chk("thr_level3", bus.fifo_level, 3);
        chk("thr_above3", bus.fifo_level_above, 1'b0);
        start(2'b10, 3'd7, 8'hFF, 6'd12, 1'b1, 8'd0);
        run_bits(64);
        stop();
        chk("thr_level4", bus.fifo_level, 4);
        chk("thr_above4", bus.fifo_level_above, 1'b1);
        drain = 1'b1;
        settle(20);
        chk("t5_drained", q.size(), 0);
        drain = 1'b0;
        bus.fifo_rd = 1'b1;
        tick();
        tick();
        chk("pop_empty_level", bus.fifo_level, 0);
        chk("pop_empty_flag", bus.fifo_empty, 1'b1);
        chk("pop_empty_rdata", bus.fifo_rdata, 0);
        $display("t5 threshold done: checks=%0d", checks);

        // reset in the middle of a frame
        samp[0] = 32'h0080_0001; samp[1] = 32'h0012_3456;
        start(2'b00, 3'd0, 8'h03, 6'd24, 1'b1, 8'd1);
        run_bits(96);
        chk("pre_rst_level", bus.fifo_level, q.size());
        chk("pre_rst_ws", ws, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_sck", sck, 1'b0);
        chk("mrst_ws", ws, 1'b0);
        chk("mrst_level", bus.fifo_level, 0);
        chk("mrst_empty", bus.fifo_empty, 1'b1);
        chk("mrst_full", bus.fifo_full, 1'b0);
        chk("mrst_overrun", bus.overrun, 1'b0);
        chk("mrst_rdata", bus.fifo_rdata, 0);
        q.delete();
        en = 1'b0;
        settle(2);
        rst_n = 1'b1;
        settle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
